// File: rtl/regfile_writer.sv
// Write-port arbiter for the 32x32 register file: single-cycle pipeline results win,
// long-latency results queue in a 2-entry FIFO, and a scoreboard flags pending sources.
module regfile_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_num,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_num,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        issue_en,
    input  logic [4:0]  issue_num,
    input  logic [4:0]  read1_num,
    input  logic [4:0]  read2_num,
    output logic        read1_busy,
    output logic        read2_busy,
    output logic [4:0]  write_num,
    output logic [31:0] write_data,
    output logic        write_en
);
    localparam int DEPTH = 2;

    logic [4:0]  fifo_num_reg  [DEPTH];
    logic [31:0] fifo_data_reg [DEPTH];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  count_reg;
    logic [31:0] pending_reg;
    logic [31:0] pending_next;

    logic        pipe_active;
    logic        fifo_accept;
    logic        fifo_push;
    logic        fifo_pop;
    logic [4:0]  head_num;
    logic [31:0] head_data;

    assign pipe_active = pipe_wen && (pipe_num != 5'd0);
    assign lu_ready    = (count_reg != 2'd2);
    // r0 results complete the handshake but are dropped instead of stored.
    assign fifo_accept = lu_valid && lu_ready;
    assign fifo_push   = fifo_accept && (lu_num != 5'd0);
    assign fifo_pop    = (count_reg != 2'd0) && !pipe_active;
    assign head_num    = fifo_num_reg[rd_ptr_reg];
    assign head_data   = fifo_data_reg[rd_ptr_reg];

    always_comb begin
        write_en   = 1'b0;
        write_num  = 5'd0;
        write_data = 32'd0;
        if (!rst) begin
            if (pipe_active) begin
                write_en   = 1'b1;
                write_num  = pipe_num;
                write_data = pipe_data;
            end else if (count_reg != 2'd0) begin
                write_en   = 1'b1;
                write_num  = head_num;
                write_data = head_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (fifo_push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_num_reg[gi]  <= lu_num;
                    fifo_data_reg[gi] <= lu_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (fifo_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (fifo_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({fifo_push, fifo_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Clear before set so a same-cycle re-issue of the popped register stays pending.
    always_comb begin
        pending_next = pending_reg;
        if (fifo_pop)
            pending_next[head_num] = 1'b0;
        if (issue_en && (issue_num != 5'd0))
            pending_next[issue_num] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending_reg <= 32'd0;
        else
            pending_reg <= pending_next;
    end

    assign read1_busy = pending_reg[read1_num];
    assign read2_busy = pending_reg[read2_num];
endmodule
